// File: rtl/nibble_seq_pkg.sv
// nibble_seq_pkg: shared table-entry layout and sequencer state encoding
package nibble_seq_pkg;
  localparam int ENTRY_W    = 28;
  localparam int SEL_A_LSB  = 0;
  localparam int SEL_B_LSB  = 12;
  localparam int SEL_AB_LSB = 24;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/nibble_out_fifo.sv
// nibble_out_fifo: synchronous FIFO with flush, occupancy count and zeroed head when empty
module nibble_out_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET_L,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop_i && cnt_q != '0;
  assign count_o = cnt_q;
  assign dout_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;

  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= push_i ? nxt(wr_q) : wr_q;
      rd_q  <= do_pop ? nxt(rd_q) : rd_q;
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end

  always_ff @(posedge CLK)
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;

  // The issuing side holds credits, so a push into a full FIFO is a design bug
  assert property (@(posedge CLK) disable iff (!RESET_L)
    !(push_i && !do_pop && !flush_i && cnt_q == CW'(DEPTH)));
endmodule

// File: rtl/nibble_sel_sequencer.sv
// nibble_sel_sequencer: steps a selector4 through a programmed table and queues the
// resulting NIBBLES words, tracking the selector's one-cycle registered latency.
module nibble_sel_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RESET_L,
  input  logic               CFG_WE,
  input  logic [AW-1:0]      CFG_ADDR,
  input  logic [ENTRY_W-1:0] CFG_DATA,
  input  logic               START,
  input  logic [AW:0]        SEQ_LEN,
  input  logic               LOOP,
  input  logic               ABORT,
  output logic [11:0]        SEL_A,
  output logic [11:0]        SEL_B,
  output logic [3:0]         SEL_AB,
  input  logic [15:0]        NIBBLES_IN,
  output logic [15:0]        OUT_NIBBLES,
  output logic               OUT_LAST,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);
  state_e             state_q;
  logic [ENTRY_W-1:0] tbl_q [DEPTH];
  logic [ENTRY_W-1:0] sel_q;
  logic [AW-1:0]      idx_q;
  logic [AW:0]        len_q;
  logic               loop_q, v1_q, v2_q, last1_q, last2_q, done_q, err_q;
  logic [CW-1:0]      fifo_cnt;
  logic [16:0]        head;
  logic               pop, len_ok, issue, at_last, drained;

  assign pop     = OUT_VALID && OUT_READY;
  assign len_ok  = SEQ_LEN != '0 && SEQ_LEN <= (AW+1)'(DEPTH);
  // Words in flight through the selector count against FIFO space
  assign issue   = state_q == RUN && 32'(fifo_cnt) + 32'(v1_q) + 32'(v2_q) < 32'(FIFO_DEPTH);
  assign at_last = {1'b0, idx_q} == len_q - (AW+1)'(1);
  assign drained = !v1_q && !v2_q && (fifo_cnt == '0 || (fifo_cnt == CW'(1) && pop));

  always_ff @(posedge CLK)
    if (CFG_WE && state_q == IDLE) tbl_q[CFG_ADDR] <= CFG_DATA;

  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L) begin
      state_q <= IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      last1_q <= 1'b0;
      last2_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      v1_q    <= 1'b0;
      v2_q    <= v1_q;
      last2_q <= last1_q;
      done_q  <= 1'b0;
      err_q   <= (CFG_WE && state_q != IDLE) || (!ABORT && START && state_q == IDLE && !len_ok);
      if (ABORT) begin
        state_q <= IDLE;
        v2_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE:
            if (START && len_ok) begin
              state_q <= RUN;
              len_q   <= SEQ_LEN;
              loop_q  <= LOOP;
              idx_q   <= '0;
            end
          RUN:
            if (issue) begin
              sel_q   <= tbl_q[idx_q];
              v1_q    <= 1'b1;
              last1_q <= at_last;
              idx_q   <= at_last ? '0 : idx_q + AW'(1);
              state_q <= (at_last && !loop_q) ? DRAIN : RUN;
            end
          DRAIN:
            if (drained) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          default: state_q <= IDLE;
        endcase
      end
    end

  nibble_out_fifo #(.W(17), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .flush_i (ABORT),
    .push_i  (v2_q),
    .din_i   ({last2_q, NIBBLES_IN}),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_cnt)
  );

  assign SEL_A       = sel_q[SEL_A_LSB +: 12];
  assign SEL_B       = sel_q[SEL_B_LSB +: 12];
  assign SEL_AB      = sel_q[SEL_AB_LSB +: 4];
  assign OUT_VALID   = fifo_cnt != '0;
  assign OUT_NIBBLES = head[15:0];
  assign OUT_LAST    = head[16];
  assign BUSY        = state_q != IDLE;
  assign DONE        = done_q;
  assign ERR         = err_q;
endmodule

// File: tb/tb_nibble_sel_sequencer.sv
// tb_nibble_sel_sequencer: random tables and consumer backpressure against a
// table-position reference model, with a stand-in registered selector.
module tb_nibble_sel_sequencer;
  localparam int DEPTH = 8;
  logic        CLK = 1'b0, RESET_L = 1'b0, CFG_WE = 1'b0, START = 1'b0, LOOP = 1'b0, ABORT = 1'b0;
  logic        OUT_READY;
  logic [2:0]  CFG_ADDR = '0;
  logic [27:0] CFG_DATA = '0;
  logic [3:0]  SEQ_LEN = '0;
  logic [11:0] SEL_A, SEL_B;
  logic [3:0]  SEL_AB;
  logic [15:0] NIBBLES_IN, OUT_NIBBLES;
  logic        OUT_LAST, OUT_VALID, BUSY, DONE, ERR;
  logic [27:0] sel;
  logic [27:0] shadow [DEPTH];
  int n_cmp = 0, n_bad = 0, done_cnt = 0, err_cnt = 0, n_words = 0;
  int m_len = 1, m_pos = 0, rdy_mode = 1;

  nibble_sel_sequencer dut (
    .CLK(CLK), .RESET_L(RESET_L), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .START(START), .SEQ_LEN(SEQ_LEN), .LOOP(LOOP), .ABORT(ABORT),
    .SEL_A(SEL_A), .SEL_B(SEL_B), .SEL_AB(SEL_AB), .NIBBLES_IN(NIBBLES_IN),
    .OUT_NIBBLES(OUT_NIBBLES), .OUT_LAST(OUT_LAST), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  assign sel = {SEL_AB, SEL_B, SEL_A};

  function automatic logic [15:0] f(input logic [27:0] e);
    return {e[27:24], e[11:6] ^ e[17:12], e[23:18] ^ e[5:0]};
  endfunction

  always_ff @(posedge CLK or negedge RESET_L)
    if (!RESET_L) NIBBLES_IN <= '0;
    else NIBBLES_IN <= f(sel);

  always @(posedge CLK) begin
    #2;
    OUT_READY = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word k of a pass is table[k mod len]; the last position of each pass is tagged
  always @(negedge CLK)
    if (RESET_L) begin
      if (OUT_VALID && OUT_READY) begin
        chk("word", 32'({OUT_LAST, OUT_NIBBLES}), 32'({m_pos == m_len - 1, f(shadow[m_pos])}));
        m_pos = (m_pos + 1) % m_len;
        n_words++;
      end
      if (DONE) begin
        done_cnt++;
        chk("busy_at_done", 32'(BUSY), 32'(0));
      end
      if (ERR) err_cnt++;
    end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic write_entry(input int a, input logic [27:0] d);
    CFG_WE = 1'b1;
    CFG_ADDR = a[2:0];
    CFG_DATA = d;
    tick;
    CFG_WE = 1'b0;
    shadow[a] = d;
  endtask

  task automatic program_random;
    for (int i = 0; i < DEPTH; i++) write_entry(i, 28'($urandom()));
  endtask

  task automatic start_cmd(input int len, input logic lp);
    SEQ_LEN = 4'(len);
    LOOP = lp;
    START = 1'b1;
    tick;
    START = 1'b0;
  endtask

  task automatic start_run(input int len, input logic lp);
    m_len = len;
    m_pos = 0;
    start_cmd(len, lp);
  endtask

  task automatic wait_done(input string tag);
    int base = done_cnt;
    for (int i = 0; i < 300 && done_cnt == base; i++) tick;
    chk(tag, 32'(done_cnt - base), 32'(1));
  endtask

  initial begin
    int w0, d0, e0, len;
    repeat (3) tick;
    chk("rst_sel", 32'(sel), 32'(0));
    chk("rst_out", 32'({OUT_VALID, OUT_LAST, OUT_NIBBLES}), 32'(0));
    chk("rst_ctl", 32'({BUSY, DONE, ERR}), 32'(0));
    RESET_L = 1'b1;
    tick;

    program_random;
    w0 = n_words;
    start_run(3, 1'b0);
    chk("t1_busy", 32'(BUSY), 32'(1));
    tick;
    chk("t1_sel0", 32'(sel), 32'(shadow[0]));
    chk("t1_ov0", 32'(OUT_VALID), 32'(0));
    tick;
    chk("t1_sel1", 32'(sel), 32'(shadow[1]));
    chk("t1_ov1", 32'(OUT_VALID), 32'(0));
    tick;
    chk("t1_sel2", 32'(sel), 32'(shadow[2]));
    chk("t1_head0", 32'({OUT_VALID, OUT_LAST, OUT_NIBBLES}), 32'({2'b10, f(shadow[0])}));
    tick;
    chk("t1_head1", 32'({OUT_VALID, OUT_LAST, OUT_NIBBLES}), 32'({2'b10, f(shadow[1])}));
    tick;
    chk("t1_head2", 32'({OUT_VALID, OUT_LAST, OUT_NIBBLES}), 32'({2'b11, f(shadow[2])}));
    tick;
    chk("t1_done", 32'({DONE, BUSY, OUT_VALID}), 32'(3'b100));
    tick;
    chk("t1_done_once", 32'(DONE), 32'(0));
    chk("t1_words", 32'(n_words - w0), 32'(3));

    rdy_mode = 0;
    w0 = n_words;
    start_run(8, 1'b0);
    repeat (14) tick;
    chk("stall_sel", 32'(sel), 32'(shadow[3]));
    chk("stall_ov", 32'({OUT_VALID, BUSY}), 32'(2'b11));
    rdy_mode = 1;
    wait_done("stall_done");
    chk("stall_words", 32'(n_words - w0), 32'(8));

    e0 = err_cnt;
    start_cmd(0, 1'b0);
    chk("len0_err", 32'({ERR, BUSY}), 32'(2'b10));
    start_cmd(9, 1'b0);
    chk("len9_err", 32'({ERR, BUSY}), 32'(2'b10));
    tick;
    chk("len_err_cnt", 32'(err_cnt - e0), 32'(2));
    chk("len_idle", 32'(BUSY), 32'(0));

    program_random;
    rdy_mode = 2;
    w0 = n_words;
    start_run(2, 1'b1);
    repeat (40) tick;
    chk("loop_words", 32'(n_words - w0 >= 6), 32'(1));
    d0 = done_cnt;
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    chk("abort_state", 32'({BUSY, OUT_VALID}), 32'(0));
    repeat (3) tick;
    chk("abort_nodone", 32'(done_cnt - d0), 32'(0));

    rdy_mode = 1;
    e0 = err_cnt;
    start_run(4, 1'b0);
    CFG_WE = 1'b1;
    CFG_ADDR = 3'd1;
    CFG_DATA = ~shadow[1];
    tick;
    CFG_WE = 1'b0;
    chk("cfg_busy_err", 32'(ERR), 32'(1));
    wait_done("cfg_done1");
    w0 = n_words;
    start_run(4, 1'b0);
    wait_done("cfg_done2");
    chk("cfg_words", 32'(n_words - w0), 32'(4));

    rdy_mode = 2;
    start_run(8, 1'b1);
    repeat (7) tick;
    #2;
    RESET_L = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'(0));
    chk("arst_out", 32'({OUT_VALID, OUT_LAST, OUT_NIBBLES}), 32'(0));
    chk("arst_ctl", 32'({BUSY, DONE, ERR}), 32'(0));
    #10;
    RESET_L = 1'b1;
    tick;

    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) program_random;
      len = $urandom_range(1, DEPTH);
      w0 = n_words;
      start_run(len, 1'b0);
      wait_done("rand_done");
      chk("rand_words", 32'(n_words - w0), 32'(len));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
